// File: rtl/tail_light_seq.sv
// Thunderbird-style tail-light sequencer: three lamps per side, turn sequencing, brake and hazard.
// Optional macro TURN_COMPLETE_EN lets an abandoned turn sequence run to its off state before leaving.
module tail_light_seq #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic brake,
  input  logic alarm,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    M_IDLE,
    M_BRAKE,
    M_LEFT,
    M_RIGHT,
    M_HAZARD
  } mode_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BRAKE,
    S_L1,
    S_L2,
    S_L3,
    S_L0,
    S_R1,
    S_R2,
    S_R3,
    S_R0,
    S_H_ON,
    S_H_OFF
  } state_t;

  state_t           state;
  state_t           state_d;
  mode_t            req;
  mode_t            req_q;
  logic [CNT_W-1:0] cnt;
  logic             side_brake;
  logic             side_brake_d;
  logic             mode_change;
  logic             tick;
  logic             finishing;
  logic [5:0]       lamps;   // {lc, lb, la, rc, rb, ra}

  function automatic mode_t mode_of(state_t s);
    case (s)
      S_BRAKE:                   return M_BRAKE;
      S_L1, S_L2, S_L3, S_L0:    return M_LEFT;
      S_R1, S_R2, S_R3, S_R0:    return M_RIGHT;
      S_H_ON, S_H_OFF:           return M_HAZARD;
      default:                   return M_IDLE;
    endcase
  endfunction

  function automatic state_t entry_of(mode_t m);
    case (m)
      M_BRAKE:  return S_BRAKE;
      M_LEFT:   return S_L1;
      M_RIGHT:  return S_R1;
      M_HAZARD: return S_H_ON;
      default:  return S_IDLE;
    endcase
  endfunction

  function automatic state_t advance(state_t s);
    case (s)
      S_L1:    return S_L2;
      S_L2:    return S_L3;
      S_L3:    return S_L0;
      S_L0:    return S_L1;
      S_R1:    return S_R2;
      S_R2:    return S_R3;
      S_R3:    return S_R0;
      S_R0:    return S_R1;
      S_H_ON:  return S_H_OFF;
      S_H_OFF: return S_H_ON;
      default: return s;
    endcase
  endfunction

  // Lamp image for a state; the idle side of a turn shows the brake lights.
  function automatic logic [5:0] decode(state_t s, logic brk);
    logic [2:0] side;
    side = brk ? 3'b111 : 3'b000;
    case (s)
      S_BRAKE: return 6'b111_111;
      S_L1:    return {3'b001, side};
      S_L2:    return {3'b011, side};
      S_L3:    return {3'b111, side};
      S_L0:    return {3'b000, side};
      S_R1:    return {side, 3'b001};
      S_R2:    return {side, 3'b011};
      S_R3:    return {side, 3'b111};
      S_R0:    return {side, 3'b000};
      S_H_ON:  return 6'b111_111;
      default: return 6'b000_000;
    endcase
  endfunction

  always_comb begin
    if (alarm || (left && right)) req = M_HAZARD;
    else if (left)                req = M_LEFT;
    else if (right)               req = M_RIGHT;
    else if (brake)               req = M_BRAKE;
    else                          req = M_IDLE;
  end

  // A new request is itself a tick, so the entry state is held a full STEP_CYCLES.
  assign mode_change = (req != req_q);
  assign tick        = mode_change || (cnt == CNT_LAST);

  always_comb begin
`ifdef TURN_COMPLETE_EN
    finishing = (state inside {S_L1, S_L2, S_L3, S_R1, S_R2, S_R3}) && (req != M_HAZARD);
`else
    finishing = 1'b0;
`endif
  end

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    state_d      = state;
    side_brake_d = side_brake;
    if (tick) begin
      side_brake_d = brake;
      if (mode_of(state) == req || finishing) state_d = advance(state);
      else                                    state_d = entry_of(req);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      req_q      <= M_IDLE;
      cnt        <= '0;
      side_brake <= 1'b0;
      lamps      <= '0;
    end else begin
      req_q      <= req;
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      state      <= state_d;
      side_brake <= side_brake_d;
      lamps      <= decode(state_d, side_brake_d);
    end
  end

  assign {lc, lb, la, rc, rb, ra} = lamps;

endmodule

// File: tb/tb_tail_light_seq.sv
// Self-checking bench for tail_light_seq: two instances (STEP_CYCLES 1 and 3) against a step-level model.
module tb_tail_light_seq;

  logic clk = 1'b0;
  logic reset;
  logic left, right, brake, alarm;
  logic la1, lb1, lc1, ra1, rb1, rc1;
  logic la3, lb3, lc3, ra3, rb3, rc3;
  logic [5:0] obs [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tail_light_seq #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .left(left), .right(right), .brake(brake), .alarm(alarm),
    .la(la1), .lb(lb1), .lc(lc1), .ra(ra1), .rb(rb1), .rc(rc1)
  );

  tail_light_seq #(.STEP_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .left(left), .right(right), .brake(brake), .alarm(alarm),
    .la(la3), .lb(lb3), .lc(lc3), .ra(ra3), .rb(rb3), .rc(rc3)
  );

  assign obs[0] = {lc1, lb1, la1, rc1, rb1, ra1};
  assign obs[1] = {lc3, lb3, la3, rc3, rb3, ra3};

`ifdef TURN_COMPLETE_EN
  localparam bit TURN_COMPLETE = 1'b1;
`else
  localparam bit TURN_COMPLETE = 1'b0;
`endif

  // Reference model: mode 0 idle, 1 brake, 2 left, 3 right, 4 hazard.
  // phase = number of lit turn lamps (0..3); for hazard 1 = on, 0 = off.
  int steps   [2] = '{1, 3};
  int m_mode  [2];
  int m_phase [2];
  int m_cnt   [2];
  int m_prev  [2];
  bit m_brk   [2];

  function automatic int req_mode();
    if (alarm || (left && right)) return 4;
    if (left)  return 2;
    if (right) return 3;
    if (brake) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_phase[k] = 0; m_cnt[k] = 0; m_prev[k] = 0; m_brk[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    int  r;
    bit  tick;
    if (!reset) begin
      model_reset();
      return;
    end
    r = req_mode();
    for (int k = 0; k < 2; k++) begin
      tick      = (r != m_prev[k]) || (m_cnt[k] == steps[k] - 1);
      m_prev[k] = r;
      m_cnt[k]  = tick ? 0 : m_cnt[k] + 1;
      if (tick) begin
        m_brk[k] = brake;
        if (m_mode[k] == r)
          m_phase[k] = (r == 4) ? 1 - m_phase[k] : (m_phase[k] + 1) % 4;
        else if (TURN_COMPLETE && (m_mode[k] == 2 || m_mode[k] == 3) && m_phase[k] != 0 && r != 4)
          m_phase[k] = (m_phase[k] + 1) % 4;
        else begin
          m_mode[k]  = r;
          m_phase[k] = 1;
        end
      end
    end
  endtask

  function automatic logic [5:0] model_out(int k);
    logic [2:0] lit;
    logic [2:0] side;
    lit  = 3'((1 << m_phase[k]) - 1);
    side = m_brk[k] ? 3'b111 : 3'b000;
    case (m_mode[k])
      1:       return 6'b111_111;
      2:       return {lit, side};
      3:       return {side, lit};
      4:       return (m_phase[k] != 0) ? 6'b111_111 : 6'b000_000;
      default: return 6'b000_000;
    endcase
  endfunction

  task automatic check(string tag, logic [5:0] observed, logic [5:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // One clock: model follows the edge, both DUTs are compared at the falling edge.
  task automatic step(string tag, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      check($sformatf("%s_s1_%0d", tag, i), obs[0], model_out(0));
      check($sformatf("%s_s3_%0d", tag, i), obs[1], model_out(1));
    end
  endtask

  task automatic drive(bit l, bit r, bit b, bit a);
    left = l; right = r; brake = b; alarm = a;
  endtask

  logic [2:0] left_pat [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
  logic [5:0] haz_pat  [4] = '{6'b111111, 6'b000000, 6'b111111, 6'b000000};

  initial begin
    int hold;
    int pick;

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("reset_s1_%0d", i), obs[0], 6'b0);
      check($sformatf("reset_s3_%0d", i), obs[1], 6'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("idle0", 2);

    // Left turn, fixed pattern on the STEP_CYCLES=1 instance.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("left", 1);
      check($sformatf("left_pat_%0d", i), obs[0], {left_pat[i % 4], 3'b000});
    end

    // Left to right switch, mid-sequence and at the off state.
    drive(1'b0, 1'b0, 1'b0, 1'b0); step("idle1", 12);
    drive(1'b1, 1'b0, 1'b0, 1'b0); step("l2r_l", 4);
    drive(1'b0, 1'b1, 1'b0, 1'b0); step("l2r_r", 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0); step("r2l_l", 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0); step("mid_r", 8);

    // Brake alone, then brake with left.
    drive(1'b0, 1'b0, 1'b0, 1'b0); step("idle2", 12);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("brake", 1);
      check($sformatf("brake_on_%0d", i), obs[0], 6'b111111);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step("brk_left", 1);
      check($sformatf("brk_left_%0d", i), obs[0], {left_pat[i % 4], 3'b111});
    end

    // Hazard with brake, then left+right without alarm.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step("haz_alarm", 1);
      check($sformatf("haz_alarm_%0d", i), obs[0], haz_pat[i]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0); step("idle3", 12);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("haz_lr", 1);
      check($sformatf("haz_lr_%0d", i), obs[0], haz_pat[i]);
    end

    // Prescaler: each left pattern held three cycles.
    drive(1'b0, 1'b0, 1'b0, 1'b0); step("idle4", 12);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step("presc", 1);
      check($sformatf("presc_pat_%0d", i), obs[1], {left_pat[(i / 3) % 4], 3'b000});
    end

    // Asynchronous reset mid-cycle, then restart at L1.
    @(posedge clk);
    model_update();
    #2 reset = 1'b0;
    #1;
    check("async_rst_s1", obs[0], 6'b0);
    check("async_rst_s3", obs[1], 6'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step("restart", 1);
    check("restart_l1", obs[0], 6'b001_000);
    step("restart", 5);

    // Randomized segment: inputs held for random durations, rare reset pulses.
    for (int seg = 0; seg < 80; seg++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1, 2: drive(1'b1, 1'b0, 1'($urandom), 1'b0);
        3, 4, 5: drive(1'b0, 1'b1, 1'($urandom), 1'b0);
        6:       drive(1'b0, 1'b0, 1'b1, 1'b0);
        7:       drive(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        8:       drive(1'b1, 1'b1, 1'($urandom), 1'b0);
        default: drive(1'b0, 1'b0, 1'b0, 1'b0);
      endcase
      reset = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      hold  = int'($urandom_range(1, 8));
      step($sformatf("rand%0d", seg), hold);
      reset = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
